// File: rtl/chess_pkg.sv
// Shared encodings for the piece move generator: square bits, colours,
// direction indices and controller states.
package chess_pkg;

  localparam int SQ_OCC   = 0;
  localparam int SQ_BLACK = 1;
  localparam int SQ_KING  = 2;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  typedef enum logic [2:0] {
    K_UPLEFT    = 3'd0,
    K_LEFT      = 3'd1,
    K_DOWNLEFT  = 3'd2,
    K_DOWN      = 3'd3,
    K_RIGHTDOWN = 3'd4,
    K_RIGHT     = 3'd5,
    K_UPRIGHT   = 3'd6,
    K_UP        = 3'd7
  } king_dir_e;

  typedef enum logic [2:0] {
    P_DIAG_RIGHT = 3'd0,
    P_DIAG_LEFT  = 3'd1,
    P_FWD        = 3'd2,
    P_DOUBLE     = 3'd3
  } pawn_dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/move_check.sv
// Combinational legality check of one king/pawn candidate move.
// Pawn double step is only legal when PAWN_DOUBLE_STEP_EN is defined.
module move_check
  import chess_pkg::*;
#(
  parameter  int BOARD_DIM = 8,
  localparam int CW        = $clog2(BOARD_DIM)
) (
  input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0][2:0] board,
  input  logic [CW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic          color,
  input  logic          is_king,
  input  logic [2:0]    cand,
  output logic          legal,
  output logic [CW-1:0] dest_row,
  output logic [CW-1:0] dest_col,
  output logic          capture,
  output logic          check
);

  // Two extra bits so that -2 and BOARD_DIM+1 are representable without wrap.
  localparam int SW = CW + 2;
  localparam logic signed [SW-1:0] P1    = SW'(1);
  localparam logic signed [SW-1:0] M1    = -P1;
  localparam logic signed [SW-1:0] DIM_S = SW'(BOARD_DIM);

  logic signed [SW-1:0] fwd, dr, dc, nr, nc;
  logic       on_board, empty, enemy, dbl_ok;
  logic [2:0] dsq;

  always_comb begin
    fwd = (color == COLOR_BLACK) ? P1 : M1;
    dr  = '0;
    dc  = '0;
    if (is_king) begin
      case (cand)
        K_UP:        dr = M1;
        K_UPRIGHT:   begin dr = M1; dc = P1; end
        K_RIGHT:     dc = P1;
        K_RIGHTDOWN: begin dr = P1; dc = P1; end
        K_DOWN:      dr = P1;
        K_DOWNLEFT:  begin dr = P1; dc = M1; end
        K_LEFT:      dc = M1;
        default:     begin dr = M1; dc = M1; end
      endcase
    end else begin
      case (cand)
        P_DOUBLE:    dr = fwd + fwd;
        P_FWD:       dr = fwd;
        P_DIAG_LEFT: begin dr = fwd; dc = M1; end
        default:     begin dr = fwd; dc = P1; end
      endcase
    end
    nr       = $signed({2'b00, row}) + dr;
    nc       = $signed({2'b00, col}) + dc;
    on_board = !nr[SW-1] && !nc[SW-1] && (nr < DIM_S) && (nc < DIM_S);
    dest_row = nr[CW-1:0];
    dest_col = nc[CW-1:0];
    dsq      = on_board ? board[dest_row][dest_col] : 3'b000;
    empty    = !dsq[SQ_OCC];
    enemy    = dsq[SQ_OCC] && (dsq[SQ_BLACK] != color);
  end

`ifdef PAWN_DOUBLE_STEP_EN
  localparam logic [CW-1:0] HOME_W = CW'(BOARD_DIM - 2);
  localparam logic [CW-1:0] HOME_B = CW'(1);
  logic signed [SW-1:0] mr;
  logic [2:0]           msq;

  // The intermediate square is on the board whenever the destination is.
  always_comb begin
    mr     = $signed({2'b00, row}) + fwd;
    msq    = on_board ? board[mr[CW-1:0]][col] : 3'b000;
    dbl_ok = !msq[SQ_OCC] && (row == ((color == COLOR_WHITE) ? HOME_W : HOME_B));
  end
`else
  assign dbl_ok = 1'b0;
`endif

  always_comb begin
    if (is_king) begin
      legal = on_board && (empty || enemy);
    end else begin
      case (cand)
        P_DOUBLE: legal = on_board && empty && dbl_ok;
        P_FWD:    legal = on_board && empty;
        default:  legal = on_board && enemy;
      endcase
    end
    capture = legal && enemy;
    check   = capture && dsq[SQ_KING];
  end

endmodule

// File: rtl/piece_move_gen.sv
// Enumerates the legal moves of one king or pawn as a ready/valid stream.
// Define PAWN_DOUBLE_STEP_EN to add the pawn double step (candidate 3).
module piece_move_gen
  import chess_pkg::*;
#(
  parameter  int BOARD_DIM = 8,
  localparam int CW        = $clog2(BOARD_DIM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_king,
  input  logic          color,
  input  logic [CW-1:0] row,
  input  logic [CW-1:0] column,
  input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0][2:0] board,
  output logic          busy,
  output logic          mv_valid,
  input  logic          mv_ready,
  output logic [CW-1:0] mv_row,
  output logic [CW-1:0] mv_col,
  output logic [2:0]    mv_dir,
  output logic          mv_capture,
  output logic          mv_check,
  output logic          done,
  output logic [3:0]    move_count
);

`ifdef PAWN_DOUBLE_STEP_EN
  localparam logic [2:0] PAWN_FIRST = 3'(P_DOUBLE);
`else
  localparam logic [2:0] PAWN_FIRST = 3'(P_FWD);
`endif
  localparam logic [2:0] KING_FIRST = 3'(K_UP);

  state_e        state_q;
  logic [2:0]    cand_q;
  logic [BOARD_DIM-1:0][BOARD_DIM-1:0][2:0] board_q;
  logic [CW-1:0] row_q, col_q;
  logic          color_q, king_q;
  logic          busy_q, mv_valid_q, done_q, mv_capture_q, mv_check_q;
  logic [CW-1:0] mv_row_q, mv_col_q;
  logic [2:0]    mv_dir_q;
  logic [3:0]    move_count_q;

  logic          chk_legal, chk_capture, chk_check;
  logic [CW-1:0] chk_row, chk_col;
  logic          start_ok;

  assign start_ok = start && (state_q == ST_IDLE);

  // Snapshot is data only; it is meaningless outside an enumeration.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      board_q <= board;
      row_q   <= row;
      col_q   <= column;
      color_q <= color;
      king_q  <= is_king;
    end
  end

  move_check #(.BOARD_DIM(BOARD_DIM)) u_check (
    .board    (board_q),
    .row      (row_q),
    .col      (col_q),
    .color    (color_q),
    .is_king  (king_q),
    .cand     (cand_q),
    .legal    (chk_legal),
    .dest_row (chk_row),
    .dest_col (chk_col),
    .capture  (chk_capture),
    .check    (chk_check)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cand_q       <= '0;
      busy_q       <= 1'b0;
      mv_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      mv_capture_q <= 1'b0;
      mv_check_q   <= 1'b0;
      mv_row_q     <= '0;
      mv_col_q     <= '0;
      mv_dir_q     <= '0;
      move_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_SCAN;
            busy_q       <= 1'b1;
            move_count_q <= '0;
            cand_q       <= is_king ? KING_FIRST : PAWN_FIRST;
          end
        end
        ST_SCAN: begin
          if (chk_legal) begin
            state_q      <= ST_EMIT;
            mv_valid_q   <= 1'b1;
            mv_row_q     <= chk_row;
            mv_col_q     <= chk_col;
            mv_dir_q     <= cand_q;
            mv_capture_q <= chk_capture;
            mv_check_q   <= chk_check;
          end else if (cand_q == 3'd0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cand_q <= cand_q - 3'd1;
          end
        end
        ST_EMIT: begin
          if (mv_ready) begin
            mv_valid_q   <= 1'b0;
            move_count_q <= move_count_q + 4'd1;
            if (cand_q == 3'd0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SCAN;
              cand_q  <= cand_q - 3'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign mv_valid   = mv_valid_q;
  assign mv_row     = mv_row_q;
  assign mv_col     = mv_col_q;
  assign mv_dir     = mv_dir_q;
  assign mv_capture = mv_capture_q;
  assign mv_check   = mv_check_q;
  assign done       = done_q;
  assign move_count = move_count_q;

endmodule

// File: tb/tb_piece_move_gen.sv
// Randomized and directed bench for piece_move_gen against a move-list model.
module tb_piece_move_gen;

`ifdef PAWN_DOUBLE_STEP_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  typedef struct {
    int dir;
    int r;
    int c;
    bit cap;
    bit chk;
  } mv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic is_king = 1'b0;
  logic color = 1'b0;
  logic [2:0] row = '0;
  logic [2:0] col = '0;
  logic mv_ready = 1'b0;
  logic sel5 = 1'b0;
  logic [7:0][7:0][2:0] board8 = '0;
  logic [4:0][4:0][2:0] board5 = '0;

  logic busy8, valid8, cap8, chk8, done8, busy5, valid5, cap5, chk5, done5;
  logic [2:0] row8, col8, dir8, row5, col5, dir5;
  logic [3:0] cnt8, cnt5;
  logic start8, start5;

  logic       o_busy, o_valid, o_cap, o_chk, o_done;
  logic [2:0] o_row, o_col, o_dir;
  logic [3:0] o_cnt;

  bit [2:0] mb[16][16];
  mv_t exp_q[$];
  int  exp_cands;
  int  checks = 0;
  int  errors = 0;
  int  last_cnt, last_cyc;

  assign start8 = start && !sel5;
  assign start5 = start && sel5;
  assign o_busy  = sel5 ? busy5  : busy8;
  assign o_valid = sel5 ? valid5 : valid8;
  assign o_cap   = sel5 ? cap5   : cap8;
  assign o_chk   = sel5 ? chk5   : chk8;
  assign o_done  = sel5 ? done5  : done8;
  assign o_row   = sel5 ? row5   : row8;
  assign o_col   = sel5 ? col5   : col8;
  assign o_dir   = sel5 ? dir5   : dir8;
  assign o_cnt   = sel5 ? cnt5   : cnt8;

  always #5 clk = ~clk;

  piece_move_gen #(.BOARD_DIM(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_king(is_king), .color(color),
    .row(row), .column(col), .board(board8), .busy(busy8), .mv_valid(valid8),
    .mv_ready(mv_ready), .mv_row(row8), .mv_col(col8), .mv_dir(dir8),
    .mv_capture(cap8), .mv_check(chk8), .done(done8), .move_count(cnt8)
  );

  piece_move_gen #(.BOARD_DIM(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .is_king(is_king), .color(color),
    .row(row), .column(col), .board(board5), .busy(busy5), .mv_valid(valid5),
    .mv_ready(mv_ready), .mv_row(row5), .mv_col(col5), .mv_dir(dir5),
    .mv_capture(cap5), .mv_check(chk5), .done(done5), .move_count(cnt5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected move list from the rules: offsets per direction, bounds, occupancy.
  function automatic void build_model(int dim, int r, int c, bit colr, bit king);
    int kdr[8], kdc[8], pdr[4], pdc[4];
    int f, nr, nc;
    bit occ, enemy, leg;
    kdr = '{-1, 0, 1, 1, 1, 0, -1, -1};
    kdc = '{-1, -1, -1, 0, 1, 1, 1, 0};
    f   = colr ? 1 : -1;
    pdr = '{f, f, f, 2 * f};
    pdc = '{1, -1, 0, 0};
    exp_q.delete();
    exp_cands = king ? 8 : (DBL ? 4 : 3);
    for (int d = exp_cands - 1; d >= 0; d--) begin
      nr = r + (king ? kdr[d] : pdr[d]);
      nc = c + (king ? kdc[d] : pdc[d]);
      if (nr < 0 || nr >= dim || nc < 0 || nc >= dim) continue;
      occ   = mb[nr][nc][0];
      enemy = occ && (mb[nr][nc][1] != colr);
      if (king)        leg = !occ || enemy;
      else if (d == 2) leg = !occ;
      else if (d == 3) leg = !occ && !mb[r + f][c][0] && (r == (colr ? 1 : dim - 2));
      else             leg = enemy;
      if (leg) exp_q.push_back('{d, nr, nc, enemy, enemy && mb[nr][nc][2]});
    end
  endfunction

  task automatic load_boards();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) board8[r][c] = mb[r][c];
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) board5[r][c] = mb[r][c];
  endtask

  task automatic clear_mb();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mb[r][c] = 3'b000;
  endtask

  // mode 0: ready high, 1: random ready, 2: first move stalled 5 cycles.
  task automatic run_enum(input bit use5, input int r, input int c, input bit colr,
                          input bit king, input int mode);
    int  cyc, stall, moves;
    bit  fin;
    mv_t h;
    sel5 = use5;
    build_model(use5 ? 5 : 8, r, c, colr, king);
    load_boards();
    @(negedge clk);
    row = 3'(r); col = 3'(c); color = colr; is_king = king;
    mv_ready = 1'b0; start = 1'b1;
    cyc = 0; stall = 0; moves = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc > 300) begin
        chk("timeout_done", 32'(o_done), 1);
        fin = 1;
      end else if (o_done) begin
        chk("done_busy", 32'(o_busy), 0);
        chk("done_count", 32'(o_cnt), moves);
        chk("done_left", exp_q.size(), 0);
        chk("done_cycle", cyc, 1 + exp_cands + moves + stall);
        last_cnt = 32'(o_cnt);
        last_cyc = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_ignored", 32'(o_busy), 0);
        chk("count_hold", 32'(o_cnt), moves);
        fin = 1;
      end else begin
        chk("busy", 32'(o_busy), 1);
        if (o_valid) begin
          if (exp_q.size() == 0) chk("extra_move", 1, 0);
          else begin
            h = exp_q[0];
            chk("mv_dir", 32'(o_dir), h.dir);
            chk("mv_row", 32'(o_row), h.r);
            chk("mv_col", 32'(o_col), h.c);
            chk("mv_capture", 32'(o_cap), 32'(h.cap));
            chk("mv_check", 32'(o_chk), 32'(h.chk));
          end
          case (mode)
            0:       mv_ready = 1'b1;
            1:       mv_ready = 1'($urandom_range(0, 1));
            default: mv_ready = (stall >= 5);
          endcase
          if (mode == 2 && stall == 2) begin
            start = 1'b1; row = 3'd0; col = 3'd0; is_king = !king;
          end
          if (mv_ready) begin
            moves++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end else stall++;
        end else begin
          mv_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic reset_mid();
    clear_mb();
    mb[4][4] = 3'b101;
    load_boards();
    sel5 = 1'b0;
    @(negedge clk);
    row = 3'd4; col = 3'd4; color = 1'b0; is_king = 1'b1; mv_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) if (!o_valid) @(negedge clk);
    chk("rst_pre_valid", 32'(o_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_row", 32'(o_row), 0);
    chk("rst_col", 32'(o_col), 0);
    chk("rst_dir", 32'(o_dir), 0);
    chk("rst_cap", 32'(o_cap), 0);
    chk("rst_chk", 32'(o_chk), 0);
    chk("rst_cnt", 32'(o_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(o_done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle_done", 32'(o_done), 0);
  endtask

  initial begin
    int n, r, c;
    bit colr, king, use5;
    clear_mb();
    load_boards();
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy8), 0);
    chk("reset_valid", 32'(valid8), 0);
    chk("reset_done", 32'(done8), 0);
    chk("reset_cnt", 32'(cnt8), 0);
    chk("reset_dir", 32'(dir8), 0);
    chk("reset_busy5", 32'(busy5), 0);
    rst_n = 1'b1;

    // Open-board king in the centre.
    clear_mb();
    mb[4][4] = 3'b101;
    build_model(8, 4, 4, 0, 1);
    chk("pin_center_size", exp_q.size(), 8);
    chk("pin_center_first", exp_q[0].dir, 7);
    chk("pin_center_first_row", exp_q[0].r, 3);
    run_enum(0, 4, 4, 0, 1, 0);
    chk("center_count", last_cnt, 8);
    chk("center_done_cycle", last_cyc, 17);

    // Corner king: own piece blocks right, enemy king capturable diagonally.
    clear_mb();
    mb[0][0] = 3'b101; mb[1][1] = 3'b111; mb[0][1] = 3'b001;
    build_model(8, 0, 0, 0, 1);
    chk("pin_corner_size", exp_q.size(), 2);
    chk("pin_corner_dir0", exp_q[0].dir, 4);
    chk("pin_corner_rc0", exp_q[0].r * 8 + exp_q[0].c, 9);
    chk("pin_corner_cap0", 32'(exp_q[0].cap), 1);
    chk("pin_corner_chk0", 32'(exp_q[0].chk), 1);
    chk("pin_corner_dir1", exp_q[1].dir, 3);
    chk("pin_corner_rc1", exp_q[1].r * 8 + exp_q[1].c, 8);
    run_enum(0, 0, 0, 0, 1, 0);
    chk("corner_count", last_cnt, 2);

    // White pawn on its home rank with two capturable diagonals.
    clear_mb();
    mb[6][3] = 3'b001; mb[5][2] = 3'b011; mb[5][4] = 3'b011;
    build_model(8, 6, 3, 0, 0);
    n = exp_q.size();
    chk("pin_pawn_size", n, DBL ? 4 : 3);
    chk("pin_pawn_first_dir", exp_q[0].dir, DBL ? 3 : 2);
    chk("pin_pawn_first_row", exp_q[0].r, DBL ? 4 : 5);
    chk("pin_pawn_dl", exp_q[n-2].dir * 100 + exp_q[n-2].r * 10 + exp_q[n-2].c, 152);
    chk("pin_pawn_dl_cap", 32'(exp_q[n-2].cap), 1);
    chk("pin_pawn_dr", exp_q[n-1].dir * 100 + exp_q[n-1].r * 10 + exp_q[n-1].c, 54);
    chk("pin_pawn_dr_cap", 32'(exp_q[n-1].cap), 1);
    run_enum(0, 6, 3, 0, 0, 0);
    chk("pawn_count", last_cnt, DBL ? 4 : 3);

    // Stalled stream with a stray start in the middle.
    clear_mb();
    mb[4][4] = 3'b101;
    run_enum(0, 4, 4, 0, 1, 2);
    chk("stall_count", last_cnt, 8);
    chk("stall_done_cycle", last_cyc, 22);

    reset_mid();
    run_enum(0, 4, 4, 0, 1, 0);
    chk("after_rst_count", last_cnt, 8);

    // Black pawn on the last rank of a 5x5 board has nothing to do.
    clear_mb();
    mb[4][2] = 3'b011;
    run_enum(1, 4, 2, 1, 0, 0);
    chk("small_count", last_cnt, 0);
    chk("small_done_cycle", last_cyc, DBL ? 5 : 4);

    for (int it = 0; it < 60; it++) begin
      use5 = ($urandom_range(0, 3) == 0);
      for (int rr = 0; rr < 16; rr++)
        for (int cc = 0; cc < 16; cc++)
          mb[rr][cc] = ($urandom_range(0, 99) < 40) ?
                       {1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 1'b1} : 3'b000;
      r    = $urandom_range(0, use5 ? 4 : 7);
      c    = $urandom_range(0, use5 ? 4 : 7);
      colr = 1'($urandom_range(0, 1));
      king = 1'($urandom_range(0, 1));
      if (!king && $urandom_range(0, 1) == 1) r = colr ? 1 : (use5 ? 3 : 6);
      mb[r][c] = {king, colr, 1'b1};
      run_enum(use5, r, c, colr, king, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piece_move_gen.md
PIECE_MOVE_GEN -- requirements
Module: piece_move_gen

Interface
REQ-001 SHALL have parameter BOARD_DIM, default 8, board side length in squares (legal range 2..16).
REQ-002 SHALL have derived localparam CW = $clog2(BOARD_DIM), the coordinate width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to enumerate the moves of one piece.
REQ-006 SHALL have port is_king  input  1  1 = king, 0 = pawn.
REQ-007 SHALL have port color  input  1  mover colour: 0 = white (pawn moves toward row 0), 1 = black (pawn moves toward row BOARD_DIM-1).
REQ-008 SHALL have ports row and column  input  CW each  mover square; (0,0) is top-left.
REQ-009 SHALL have port board  input  [BOARD_DIM][BOARD_DIM][3]  per square: bit0 occupied, bit1 colour (1 = black), bit2 king.
REQ-010 SHALL have port busy  output  1  high from the start capture until the done pulse.
REQ-011 SHALL have ports mv_valid (output 1) and mv_ready (input 1)  move-stream handshake.
REQ-012 SHALL have ports mv_row and mv_col  output  CW each  destination square.
REQ-013 SHALL have port mv_dir  output  3  candidate index (king: 7 up, 6 upRight, 5 right, 4 rightDown, 3 down, 2 downLeft, 1 left, 0 upLeft; pawn: 2 forward, 1 diagLeft, 0 diagRight, 3 double step).
REQ-014 SHALL have ports mv_capture and mv_check  output  1 each  destination holds an enemy piece / an enemy king.
REQ-015 SHALL have ports done (output 1, one-cycle pulse) and move_count (output 4, number of moves emitted).

Function
REQ-016 On start in IDLE, the block SHALL snapshot board, row, column, color and is_king; it SHALL ignore start while busy.
REQ-017 FSM states SHALL be IDLE, SCAN, EMIT and DONE.
REQ-018 SCAN SHALL evaluate exactly one candidate per cycle, in descending mv_dir order (king 7..0; pawn 3, 2, 1, 0).
REQ-019 A king candidate SHALL be legal if it is on the board and the square is empty or holds the opposite colour.
REQ-020 Pawn forward SHALL be legal if it is on the board and the square is empty; a pawn diagonal SHALL be legal only if the square holds the opposite colour.
REQ-021 Board-edge overflow (row/column 0 minus 1, or BOARD_DIM-1 plus 1) SHALL make a candidate illegal, with no coordinate wrap-around.
REQ-022 A legal candidate SHALL register the mv_* fields, set mv_valid and enter EMIT; an illegal candidate SHALL cost exactly one cycle.
REQ-023 In EMIT, mv_valid and all mv_* fields SHALL stay stable until mv_ready is high; the transfer cycle SHALL increment move_count and resume SCAN with the next candidate, or enter DONE after the last one.
REQ-024 DONE SHALL last one cycle, pulse done, drop busy, return to IDLE and hold move_count until the next start.
REQ-025 Timing: start in cycle 0 puts the first candidate in cycle 1; with mv_ready tied high, the total is 1 + candidates + emitted moves cycles.
REQ-026 A start arriving in the DONE cycle SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force IDLE and set busy, mv_valid, done, mv_capture and mv_check to 0, mv_row, mv_col and mv_dir to 0, and move_count to 0.
REQ-028 Reset asserted mid-enumeration SHALL abandon it, with no done pulse.

Configuration
REQ-029 Macro PAWN_DOUBLE_STEP_EN defined: candidate 3 SHALL be legal when the pawn is on its home rank (white BOARD_DIM-2, black 1) and both squares ahead are empty.
REQ-030 Macro PAWN_DOUBLE_STEP_EN undefined: candidate 3 SHALL NOT be evaluated; pawn enumeration SHALL take 3 scan cycles.

Structure
REQ-031 Package chess_pkg SHALL hold the square-bit indices, the colour encoding, the king and pawn direction enums and the FSM state typedef.
REQ-032 The candidate legality check SHALL be a combinational sub-module move_check (inputs: snapshot, candidate index; outputs: legal, dest, capture, check).

Verification
REQ-033 Empty 8x8 board, white king at (4,4), ready high -> 8 moves with dirs 7..0, move_count=8, done at cycle 17.
REQ-034 White king at (0,0), black king at (1,1), white piece at (0,1) -> 2 moves: dir 4 (1,1) with capture=1 and check=1, then dir 3 (1,0); move_count=2.
REQ-035 White pawn at (6,3), black pieces at (5,2) and (5,4), macro defined -> dirs 3 (4,3), 2 (5,3), 1 (5,2, capture), 0 (5,4, capture); macro undefined -> 3 moves.
REQ-036 Move stream with mv_ready low for 5 cycles -> mv_valid and fields stable throughout; start pulsed during this stall is ignored.
REQ-037 rst_n low during EMIT -> all outputs 0 asynchronously, no done pulse; a subsequent start enumerates correctly.
REQ-038 BOARD_DIM=5, black pawn at (4,2) -> 0 moves, done at cycle 4 (macro undefined), move_count=0.
